serial_pad_reader: RTL and testbench
====================================

// Module: serial_pad_reader
// PURPOSE
//  Multi-pad serial gamepad poller, successor to the single SNES reader. Drives one shared LATCH/PULSE
//  pair, samples NUM_PADS DATA lines in parallel and supports NES (8-bit) or SNES (16-bit) frames.
//  Publishes active-high button words with a VALID strobe, per-pad change flags and pad-present
//  detection. Sits between the GPIO pad pins and the game/input logic, all in the CLOCK domain.
// PARAMETERS
//  NUM_PADS     2    number of DATA inputs / pads sampled concurrently (1..4)
//  NUM_BITS     16   bits per pad lane; SNES mode reads NUM_BITS, NES mode reads 8 (NUM_BITS>=8)
//  HALF_PERIOD  162  CLOCK cycles per tick (one half pulse period); >=2
//  GAP_TICKS    100  idle ticks between the end of one frame and the next LATCH (>=1)
// PORTS
//  CLOCK    in   1                  system clock (e.g. CLOCK_50)
//  RESET    in   1                  synchronous, active-high reset
//  ENABLE   in   1                  1 = poll continuously; 0 = stop after the current frame
//  MODE     in   1                  0 = NES (8 bits), 1 = SNES (NUM_BITS bits); sampled at frame start
//  DATA     in   NUM_PADS           serial data from each pad, active-low buttons
//  LATCH    out  1                  shared latch to all pads
//  PULSE    out  1                  shared shift clock to all pads (idles high)
//  BUTTONS  out  NUM_PADS*NUM_BITS  pad p in [p*NUM_BITS +: NUM_BITS]; bit k = k-th serial bit, 1=pressed
//  PRESENT  out  NUM_PADS           1 = pad detected in last frame
//  CHANGED  out  NUM_PADS           1 for the VALID cycle if pad p's published word changed
//  VALID    out  1                  one-CLOCK strobe when BUTTONS/PRESENT/CHANGED update
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, gap counter=0, LATCH=0, PULSE=1, BUTTONS=0, PRESENT=0,
//   CHANGED=0, VALID=0. Reset mid-frame aborts immediately; no partial word is published.
//  Tick: prescaler counts 0..HALF_PERIOD-1, tick = 1-CLOCK strobe when count==HALF_PERIOD-1.
//   Prescaler free-runs (outside reset); all FSM moves happen only on ticks.
//  FSM (transitions on tick):
//   IDLE: LATCH=0, PULSE=1. If ENABLE and gap counter==0 -> LAT1, latch MODE into nbits
//    (8 or NUM_BITS), bit index k=0. Gap counter decrements each tick while >0.
//   LAT1 -> LAT2: LATCH=1, PULSE=1 (latch high for exactly 2 ticks).
//   LAT2 -> HI: LATCH=1.
//   HI: LATCH=0, PULSE=1. On the tick leaving HI, shift ~DATA[p] into lane p bit k, all pads
//    together -> LO.
//   LO: PULSE=0. Tick: if k==nbits-1 -> DONE, else k<=k+1 -> HI.
//   DONE (one CLOCK, not tick-gated): publish, pulse VALID, load gap counter=GAP_TICKS -> IDLE.
//  Frame length: (2 + 2*nbits) ticks; SNES/16 = 34 ticks, NES = 18 ticks.
//  LATCH and PULSE are registered outputs, glitch-free, and change only on tick boundaries.
//  Publish (DONE): per pad p, PRESENT[p] = 0 if all nbits raw samples were 0 (floating/pulled-low
//   line reads as all pressed), else 1. Absent pad -> lane forced to 0. NES mode -> lane bits
//   [NUM_BITS-1:8] = 0. CHANGED[p] = (new lane != previous lane). All outputs are written in the
//   same CLOCK as VALID=1 and hold until the next DONE.
//  ENABLE deassert mid-frame: frame completes and publishes, then FSM stays in IDLE.
//   ENABLE reassert in IDLE: waits out any remaining gap.
//  MODE changes mid-frame are ignored until the next LAT1 entry.
//  Simultaneous RESET and tick/DONE: reset wins.
// TESTING (HALF_PERIOD=4, GAP_TICKS=2, NUM_PADS=2, NUM_BITS=16)
//  Reset, ENABLE=1, MODE=1 -> LATCH high exactly 8 CLOCKs, then 16 PULSE lows of 4 CLOCKs each;
//   VALID every (34+2)*4 CLOCKs.
//  Pad0 model pressing B+Start (bits 0,3), pad1 idle -> BUTTONS[15:0]=16'h0009,
//   BUTTONS[31:16]=0, PRESENT=2'b11.
//  DATA[1] tied 0 -> PRESENT[1]=0 and BUTTONS[31:16]=0; unplug/replug pad -> CHANGED pulses
//   only with VALID.
//  MODE=0 with pad0 pressing A (bit 0) -> 8 pulses/frame, lane0=16'h0001, upper byte 0.
//  Assert RESET at pulse 5 of a frame -> next CLOCK LATCH=0, PULSE=1, VALID never asserted
//   for that frame.
//  Drop ENABLE during pulse 3 -> exactly one more VALID, then LATCH stays 0.

Source files
------------

// File: rtl/serial_pad_reader.sv
// Multi-pad NES/SNES serial poller: shared LATCH/PULSE, parallel DATA lanes.
// Publishes active-high button words with VALID, PRESENT and CHANGED.
module serial_pad_reader #(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BITS    = 16,
  parameter int HALF_PERIOD = 162,
  parameter int GAP_TICKS   = 100
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         ENABLE,
  input  logic                         MODE,
  input  logic [NUM_PADS-1:0]          DATA,
  output logic                         LATCH,
  output logic                         PULSE,
  output logic [NUM_PADS*NUM_BITS-1:0] BUTTONS,
  output logic [NUM_PADS-1:0]          PRESENT,
  output logic [NUM_PADS-1:0]          CHANGED,
  output logic                         VALID
);

  localparam int PW = $clog2(HALF_PERIOD);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int KW = $clog2(NUM_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_LAT1, S_LAT2, S_HI, S_LO, S_DONE
  } state_t;

  state_t state, state_n;

  logic [PW-1:0] pre;
  logic          tick;
  logic [GW-1:0] gap_cnt;
  logic [KW-1:0] k, last;
  logic          nes;
  logic          latch_d, pulse_d;
  logic [NUM_PADS-1:0] seen;
  logic [NUM_BITS-1:0] lane [NUM_PADS];
  logic [NUM_BITS-1:0] pub  [NUM_PADS];
  logic [NUM_BITS-1:0] mask;

  assign tick = (pre == PW'(HALF_PERIOD - 1));
  assign last = nes ? KW'(7) : KW'(NUM_BITS - 1);
  assign mask = nes ? NUM_BITS'(8'hFF) : '1;

  always_ff @(posedge CLOCK) begin
    if (RESET)     pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= S_IDLE;
      LATCH <= 1'b0;
      PULSE <= 1'b1;
    end else begin
      state <= state_n;
      LATCH <= latch_d;
      PULSE <= pulse_d;
    end
  end

  // The tick that runs the gap down to zero also launches the frame.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (tick && ENABLE && gap_cnt <= GW'(1))
          state_n = S_LAT1;
      S_LAT1: if (tick) state_n = S_LAT2;
      S_LAT2: if (tick) state_n = S_HI;
      S_HI:   if (tick) state_n = S_LO;
      S_LO:
        if (tick)
          state_n = (k == last) ? S_DONE : S_HI;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    latch_d = (state_n == S_LAT1) || (state_n == S_LAT2);
    pulse_d = (state_n != S_LO);
  end

  always_comb begin
    for (int p = 0; p < NUM_PADS; p++)
      pub[p] = seen[p] ? (lane[p] & mask) : '0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      gap_cnt <= '0;
      k       <= '0;
      nes     <= 1'b0;
      seen    <= '0;
      BUTTONS <= '0;
      PRESENT <= '0;
      CHANGED <= '0;
      VALID   <= 1'b0;
      for (int p = 0; p < NUM_PADS; p++)
        lane[p] <= '0;
    end else begin
      VALID   <= 1'b0;
      CHANGED <= '0;
      if (state == S_DONE)
        gap_cnt <= GW'(GAP_TICKS);
      else if (state == S_IDLE && tick && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
      if (state == S_IDLE && state_n == S_LAT1) begin
        nes  <= ~MODE;
        k    <= '0;
        seen <= '0;
        for (int p = 0; p < NUM_PADS; p++)
          lane[p] <= '0;
      end
      // A line that never reads high is floating or pulled low: no pad.
      if (state == S_HI && tick) begin
        for (int p = 0; p < NUM_PADS; p++) begin
          lane[p][k] <= ~DATA[p];
          seen[p]    <= seen[p] | DATA[p];
        end
      end
      if (state == S_LO && tick && k != last)
        k <= k + 1'b1;
      if (state == S_DONE) begin
        VALID   <= 1'b1;
        PRESENT <= seen;
        for (int p = 0; p < NUM_PADS; p++) begin
          BUTTONS[p*NUM_BITS +: NUM_BITS] <= pub[p];
          CHANGED[p] <=
            pub[p] != BUTTONS[p*NUM_BITS +: NUM_BITS];
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_pad_reader.sv
// Directed bench for serial_pad_reader with a two-pad shift-register model.
// HALF_PERIOD=4, GAP_TICKS=2, NUM_PADS=2, NUM_BITS=16.
module tb_serial_pad_reader;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        MODE;
  logic [1:0]  DATA;
  logic        LATCH;
  logic        PULSE;
  logic [31:0] BUTTONS;
  logic [1:0]  PRESENT;
  logic [1:0]  CHANGED;
  logic        VALID;

  serial_pad_reader #(
    .NUM_PADS(2), .NUM_BITS(16),
    .HALF_PERIOD(4), .GAP_TICKS(2)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE),
    .MODE(MODE), .DATA(DATA), .LATCH(LATCH),
    .PULSE(PULSE), .BUTTONS(BUTTONS), .PRESENT(PRESENT),
    .CHANGED(CHANGED), .VALID(VALID)
  );

  always #5 CLOCK = ~CLOCK;

  logic [15:0] btn0 = '0, btn1 = '0;
  logic        plug0 = 1'b1, plug1 = 1'b1;
  logic [15:0] sr0 = '1, sr1 = '1;
  logic        pq = 1'b1;

  // Pad model: parallel load while LATCH high, shift on PULSE rising.
  always @(posedge CLOCK) begin
    pq <= PULSE;
    if (LATCH) begin
      sr0 <= ~btn0;
      sr1 <= ~btn1;
    end else if (PULSE && !pq) begin
      sr0 <= {1'b1, sr0[15:1]};
      sr1 <= {1'b1, sr1[15:1]};
    end
  end

  assign DATA = {plug1 ? sr1[0] : 1'b0, plug0 ? sr0[0] : 1'b0};

  int total = 0;
  int passed = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Runs from one VALID sample to the next, collecting frame shape.
  task automatic run_frame(output int cyc, output int lat,
                           output int pul, output int low,
                           output int stray);
    logic prev;
    cyc = 0; lat = 0; pul = 0; low = 0; stray = 0;
    prev = PULSE;
    do begin
      @(negedge CLOCK);
      cyc++;
      if (LATCH) lat++;
      if (!PULSE) low++;
      if (prev && !PULSE) pul++;
      if (CHANGED != 2'b00 && !VALID) stray++;
      prev = PULSE;
    end while (!VALID && cyc < 1000);
    check("valid_seen", {31'd0, VALID}, 32'd1);
  endtask

  task automatic wait_falls(int n);
    int c = 0, cyc = 0;
    logic prev = PULSE;
    while (c < n && cyc < 2000) begin
      @(negedge CLOCK);
      cyc++;
      if (prev && !PULSE) c++;
      prev = PULSE;
    end
    check("pulse_wait", c, n);
  endtask

  int cyc, lat, pul, low, stray, nv, lat_after;
  bit after;

  initial begin
    RESET = 1'b1; ENABLE = 1'b0; MODE = 1'b1;
    repeat (3) @(negedge CLOCK);
    check("rst_latch", {31'd0, LATCH}, 32'd0);
    check("rst_pulse", {31'd0, PULSE}, 32'd1);
    check("rst_valid", {31'd0, VALID}, 32'd0);
    check("rst_buttons", BUTTONS, 32'd0);
    check("rst_present", {30'd0, PRESENT}, 32'd0);

    btn0 = 16'h0009; btn1 = 16'h0000;
    RESET = 1'b0; ENABLE = 1'b1;
    run_frame(cyc, lat, pul, low, stray);
    check("f1_lane0", BUTTONS[15:0], 32'h0009);
    check("f1_lane1", BUTTONS[31:16], 32'h0);
    check("f1_present", {30'd0, PRESENT}, 32'd3);
    check("f1_changed", {30'd0, CHANGED}, 32'd1);

    run_frame(cyc, lat, pul, low, stray);
    check("snes_period", cyc, 144);
    check("snes_latch", lat, 8);
    check("snes_pulses", pul, 16);
    check("snes_lows", low, 64);
    check("f2_changed", {30'd0, CHANGED}, 32'd0);
    check("f2_lane0", BUTTONS[15:0], 32'h0009);

    MODE = 1'b0; btn0 = 16'h0301; btn1 = 16'h8000;
    run_frame(cyc, lat, pul, low, stray);
    check("nes_period", cyc, 80);
    check("nes_pulses", pul, 8);
    check("nes_lows", low, 32);
    check("nes_lane0", BUTTONS[15:0], 32'h0001);
    check("nes_lane1", BUTTONS[31:16], 32'h0);
    check("nes_changed", {30'd0, CHANGED}, 32'd1);

    MODE = 1'b1; btn0 = 16'h0009; plug1 = 1'b0;
    run_frame(cyc, lat, pul, low, stray);
    check("unplug_present", {30'd0, PRESENT}, 32'd1);
    check("unplug_lane1", BUTTONS[31:16], 32'h0);
    check("unplug_lane0", BUTTONS[15:0], 32'h0009);
    check("unplug_changed", {30'd0, CHANGED}, 32'd1);
    check("unplug_stray", stray, 0);

    plug1 = 1'b1;
    run_frame(cyc, lat, pul, low, stray);
    check("replug_present", {30'd0, PRESENT}, 32'd3);
    check("replug_lane1", BUTTONS[31:16], 32'h8000);
    check("replug_changed", {30'd0, CHANGED}, 32'd2);
    check("replug_stray", stray, 0);

    wait_falls(5);
    RESET = 1'b1;
    @(negedge CLOCK);
    check("midrst_latch", {31'd0, LATCH}, 32'd0);
    check("midrst_pulse", {31'd0, PULSE}, 32'd1);
    check("midrst_buttons", BUTTONS, 32'd0);
    @(negedge CLOCK);
    RESET = 1'b0; ENABLE = 1'b0;
    nv = 0;
    repeat (300) begin
      @(negedge CLOCK);
      if (VALID) nv++;
    end
    check("midrst_novalid", nv, 0);

    ENABLE = 1'b1;
    run_frame(cyc, lat, pul, low, stray);
    check("re_lane0", BUTTONS[15:0], 32'h0009);
    check("re_changed", {30'd0, CHANGED}, 32'd3);

    wait_falls(3);
    ENABLE = 1'b0;
    nv = 0; lat_after = 0; after = 0;
    repeat (400) begin
      @(negedge CLOCK);
      if (after && LATCH) lat_after++;
      if (VALID) begin
        nv++;
        after = 1;
      end
    end
    check("drop_valids", nv, 1);
    check("drop_latch", lat_after, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
